// File: rtl/count_shifter_grs_param.sv
// count_shifter_grs_param: multi-bit-per-cycle mantissa count/shift unit.
// Right-aligns with guard/round/sticky collection, left-shifts by a count,
// or normalises left until the MSB is set, under a Start/Busy/Done handshake.
//
// state | meaning
// IDLE  | waiting for Start, results held
// LOAD  | operand captured, decide whether any shifting is needed
// SHIFT | shift up to STEP positions per cycle
// DONE  | one-cycle result-valid pulse, Start accepted back-to-back
module count_shifter_grs_param #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Count,
  input  logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Guard,
  output logic             Round,
  output logic             Sticky,
  output logic [CNT_W-1:0] Shift_amt
);

  // X holds {A, G, R}; the two extra bits sit below the mantissa LSB.
  localparam int XW = WIDTH + 2;
  localparam logic [CNT_W-1:0] C_SAT   = CNT_W'(XW);
  localparam logic [CNT_W-1:0] C_STEP  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [XW-1:0]    r_x;
  logic             r_s;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_shift_amt;
  logic [1:0]       r_mode;

  logic [WIDTH-1:0] r_result;
  logic             r_guard;
  logic             r_round;
  logic             r_sticky;

  logic             w_start_ok;
  logic             w_norm;
  logic             w_left;
  logic [CNT_W-1:0] w_k_lin;
  logic [CNT_W-1:0] w_lz;
  logic             w_seen;
  logic [CNT_W-1:0] w_room;
  logic [CNT_W-1:0] w_k_norm;
  logic [XW-1:0]    w_x_nxt;
  logic             w_s_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [CNT_W-1:0] w_amt_nxt;
  logic             w_exit;
  logic [CNT_W-1:0] w_rem_load;

  assign w_start_ok = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_norm     = (r_mode == 2'b10);
  assign w_left     = (r_mode == 2'b01);

  // Right shifts beyond the full X width only feed sticky, so they are clamped.
  assign w_rem_load = (Mode == 2'b01) ? Count :
                      (Mode == 2'b10) ? '0 :
                      ((Count > C_SAT) ? C_SAT : Count);

  // One SHIFT cycle of datapath: step size, shifted X, sticky and counters.
  always_comb begin
    w_k_lin = (r_rem < C_STEP) ? r_rem : C_STEP;

    w_lz   = '0;
    w_seen = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      if (!w_seen && !r_x[XW-1-j]) begin
        w_lz = w_lz + CNT_W'(1);
      end else begin
        w_seen = 1'b1;
      end
    end
    // An all-zero operand must stop exactly at WIDTH positions.
    w_room   = C_WIDTH - r_shift_amt;
    w_k_norm = (w_lz < w_room) ? w_lz : w_room;

    w_x_nxt   = r_x;
    w_s_nxt   = r_s;
    w_rem_nxt = r_rem;
    w_amt_nxt = r_shift_amt;
    w_exit    = 1'b0;

    if (w_norm) begin
      w_x_nxt   = r_x << w_k_norm;
      w_amt_nxt = r_shift_amt + w_k_norm;
      w_exit    = w_x_nxt[XW-1] || (w_amt_nxt == C_WIDTH);
    end else if (w_left) begin
      w_x_nxt   = r_x << w_k_lin;
      w_rem_nxt = r_rem - w_k_lin;
      w_amt_nxt = r_shift_amt + w_k_lin;
      w_exit    = (w_rem_nxt == '0);
    end else begin
      w_x_nxt   = r_x >> w_k_lin;
      w_s_nxt   = r_s | (|(r_x & ~({XW{1'b1}} << w_k_lin)));
      w_rem_nxt = r_rem - w_k_lin;
      w_amt_nxt = r_shift_amt + w_k_lin;
      w_exit    = (w_rem_nxt == '0);
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; normalise always takes at least one SHIFT cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_norm || (r_rem != '0)) w_state_nxt = ST_SHIFT;
        else                         w_state_nxt = ST_DONE;
      end
      ST_SHIFT: begin
        if (w_exit) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
        else            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Working registers: load on an accepted Start, advance in SHIFT.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      r_x         <= '0;
      r_s         <= 1'b0;
      r_rem       <= '0;
      r_shift_amt <= '0;
      r_mode      <= 2'b00;
    end else if (w_start_ok) begin
      r_x         <= {Data, 2'b00};
      r_s         <= 1'b0;
      r_rem       <= w_rem_load;
      r_shift_amt <= '0;
      r_mode      <= Mode;
    end else if (r_state == ST_SHIFT) begin
      r_x         <= w_x_nxt;
      r_s         <= w_s_nxt;
      r_rem       <= w_rem_nxt;
      r_shift_amt <= w_amt_nxt;
    end
  end

  // Result registers capture the final X on the way into DONE and hold it.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      r_result <= '0;
      r_guard  <= 1'b0;
      r_round  <= 1'b0;
      r_sticky <= 1'b0;
    end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_DONE)) begin
      r_result <= r_x[XW-1:2];
      r_guard  <= r_x[1];
      r_round  <= r_x[0];
      r_sticky <= r_s;
    end else if ((r_state == ST_SHIFT) && w_exit) begin
      r_result <= w_x_nxt[XW-1:2];
      r_guard  <= w_x_nxt[1];
      r_round  <= w_x_nxt[0];
      r_sticky <= w_s_nxt;
    end
  end

  assign Busy      = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign Done      = (r_state == ST_DONE);
  assign Result    = r_result;
  assign Guard     = r_guard;
  assign Round     = r_round;
  assign Sticky    = r_sticky;
  assign Shift_amt = r_shift_amt;

endmodule

// File: tb/tb_count_shifter_grs_param.sv
// Bench for count_shifter_grs_param: STEP=1 and STEP=4 instances share the
// same stimulus and are checked against an arithmetic reference model.
module tb_count_shifter_grs_param;

  localparam int W  = 24;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Clear;
  logic          Start;
  logic [1:0]    Mode;
  logic [CW-1:0] Count;
  logic [W-1:0]  Data;

  logic          busy_o  [2];
  logic          done_o  [2];
  logic [W-1:0]  res_o   [2];
  logic          g_o     [2];
  logic          r_o     [2];
  logic          s_o     [2];
  logic [CW-1:0] amt_o   [2];

  int steps [2] = '{1, 4};
  int errs   = 0;
  int checks = 0;

  count_shifter_grs_param #(.WIDTH(W), .CNT_W(CW), .STEP(1)) u_dut1 (
    .Clk(Clk), .Clear(Clear), .Start(Start), .Mode(Mode), .Count(Count), .Data(Data),
    .Busy(busy_o[0]), .Done(done_o[0]), .Result(res_o[0]), .Guard(g_o[0]),
    .Round(r_o[0]), .Sticky(s_o[0]), .Shift_amt(amt_o[0]));

  count_shifter_grs_param #(.WIDTH(W), .CNT_W(CW), .STEP(4)) u_dut4 (
    .Clk(Clk), .Clear(Clear), .Start(Start), .Mode(Mode), .Count(Count), .Data(Data),
    .Busy(busy_o[1]), .Done(done_o[1]), .Result(res_o[1]), .Guard(g_o[1]),
    .Round(r_o[1]), .Sticky(s_o[1]), .Shift_amt(amt_o[1]));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result of the whole operation and its Start-to-Done latency.
  task automatic model(input logic [1:0] m, input logic [7:0] c, input logic [23:0] d,
                       input int step, output logic [23:0] res, output logic g,
                       output logic r, output logic s, output logic [7:0] amt, output int lat);
    longint unsigned x, xs;
    int n, lz;
    g = 1'b0; r = 1'b0; s = 1'b0;
    if (m == 2'b10) begin
      lz = 0;
      while (lz < 24 && d[23-lz] == 1'b0) lz++;
      res = d << lz;
      amt = 8'(lz);
      lat = 2 + ((lz == 0) ? 1 : (lz + step - 1) / step);
    end else if (m == 2'b01) begin
      n   = int'(c);
      res = (n >= 24) ? 24'd0 : (d << n);
      amt = c;
      lat = 2 + (n + step - 1) / step;
    end else begin
      n   = (int'(c) > 26) ? 26 : int'(c);
      x   = {38'd0, d, 2'b00};
      xs  = x >> n;
      res = xs[25:2];
      g   = xs[1];
      r   = xs[0];
      s   = (x & ((64'd1 << n) - 64'd1)) != 64'd0;
      amt = 8'(n);
      lat = 2 + (n + step - 1) / step;
    end
  endtask

  // Start has been driven just after the current edge; watch both DUTs.
  task automatic observe(input string tag, input logic [1:0] m, input logic [7:0] c,
                         input logic [23:0] d);
    logic [23:0] eres [2];
    logic        eg [2], er [2], es [2];
    logic [7:0]  eamt [2];
    int          elat [2];
    int          first [2], dcnt [2], bcnt [2];
    logic [23:0] cres [2];
    logic        cg [2], cr [2], cs [2];
    logic [7:0]  camt [2];
    int          span;
    for (int u = 0; u < 2; u++) begin
      model(m, c, d, steps[u], eres[u], eg[u], er[u], es[u], eamt[u], elat[u]);
      first[u] = -1; dcnt[u] = 0; bcnt[u] = 0;
      cres[u] = '0; cg[u] = 0; cr[u] = 0; cs[u] = 0; camt[u] = '0;
    end
    span = ((elat[0] > elat[1]) ? elat[0] : elat[1]) + 2;
    for (int i = 1; i <= span; i++) begin
      @(posedge Clk); #1;
      if (i == 1) begin
        // A second Start while busy, with new operands, must be ignored.
        Start = 1'b1;
        Data  = 24'($urandom);
        Count = 8'($urandom);
        Mode  = 2'($urandom);
      end else if (i == 2) begin
        Start = 1'b0;
      end
      for (int u = 0; u < 2; u++) begin
        if (busy_o[u]) bcnt[u]++;
        if (done_o[u]) begin
          dcnt[u]++;
          if (first[u] < 0) begin
            first[u] = i;
            cres[u] = res_o[u]; cg[u] = g_o[u]; cr[u] = r_o[u];
            cs[u] = s_o[u]; camt[u] = amt_o[u];
          end
        end
      end
    end
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s/s%0d/lat", tag, steps[u]), 32'(first[u]), 32'(elat[u]));
      check($sformatf("%s/s%0d/done_pulses", tag, steps[u]), 32'(dcnt[u]), 32'd1);
      check($sformatf("%s/s%0d/busy_cycles", tag, steps[u]), 32'(bcnt[u]), 32'(elat[u] - 1));
      check($sformatf("%s/s%0d/result", tag, steps[u]), 32'(cres[u]), 32'(eres[u]));
      check($sformatf("%s/s%0d/guard", tag, steps[u]), 32'(cg[u]), 32'(eg[u]));
      check($sformatf("%s/s%0d/round", tag, steps[u]), 32'(cr[u]), 32'(er[u]));
      check($sformatf("%s/s%0d/sticky", tag, steps[u]), 32'(cs[u]), 32'(es[u]));
      check($sformatf("%s/s%0d/shift_amt", tag, steps[u]), 32'(camt[u]), 32'(eamt[u]));
      check($sformatf("%s/s%0d/result_held", tag, steps[u]), 32'(res_o[u]), 32'(eres[u]));
    end
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [7:0] c,
                     input logic [23:0] d);
    Mode = m; Count = c; Data = d; Start = 1'b1;
    observe(tag, m, c, d);
  endtask

  task automatic check_idle(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s/s%0d/result", tag, steps[u]), 32'(res_o[u]), 32'd0);
      check($sformatf("%s/s%0d/grs", tag, steps[u]), 32'({g_o[u], r_o[u], s_o[u]}), 32'd0);
      check($sformatf("%s/s%0d/shift_amt", tag, steps[u]), 32'(amt_o[u]), 32'd0);
      check($sformatf("%s/s%0d/busy", tag, steps[u]), 32'(busy_o[u]), 32'd0);
      check($sformatf("%s/s%0d/done", tag, steps[u]), 32'(done_o[u]), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  m;
    logic [7:0]  c;
    logic [23:0] d;
    Clear = 1'b0; Start = 1'b0; Mode = 2'b00; Count = '0; Data = '0;
    #12;
    check_idle("reset");
    @(posedge Clk); #1;
    Clear = 1'b1;
    @(posedge Clk); #1;

    run("right3",    2'b00, 8'd3,   24'hC00001);
    run("right10",   2'b00, 8'd10,  24'hFFFFFF);
    run("sat200",    2'b00, 8'd200, 24'h800000);
    run("norm1234",  2'b10, 8'd0,   24'h001234);
    run("norm_zero", 2'b10, 8'd77,  24'h000000);
    run("norm_msb",  2'b10, 8'd5,   24'h800001);
    run("left0",     2'b01, 8'd0,   24'hABCDEF);
    run("left5",     2'b01, 8'd5,   24'h0F0F0F);
    run("left30",    2'b01, 8'd30,  24'hFFFFFF);
    run("mode11_30", 2'b11, 8'd30,  24'h123456);
    run("right26",   2'b00, 8'd26,  24'hFFFFFF);
    run("right1",    2'b00, 8'd1,   24'h000003);

    // Back-to-back: Start presented in the Done cycle of a Count=0 operation.
    Mode = 2'b01; Count = 8'd0; Data = 24'h5A5A5A; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("b2b_first/s%0d/done", steps[u]), 32'(done_o[u]), 32'd1);
      check($sformatf("b2b_first/s%0d/result", steps[u]), 32'(res_o[u]), 32'h5A5A5A);
    end
    run("b2b_second", 2'b00, 8'd5, 24'hF0000F);

    // Clear during SHIFT: outputs drop at once and no Done follows.
    Mode = 2'b00; Count = 8'd20; Data = 24'hFFFFFF; Start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    #2;
    Clear = 1'b0;
    #1;
    check_idle("clear_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      for (int u = 0; u < 2; u++)
        check($sformatf("clear_hold/s%0d/done", steps[u]), 32'(done_o[u]), 32'd0);
    end
    Clear = 1'b1;
    @(posedge Clk); #1;
    run("after_clear", 2'b00, 8'd7, 24'hC3C3C3);

    for (int t = 0; t < 40; t++) begin
      m = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
      d = 24'($urandom) >> $urandom_range(0, 24);
      run($sformatf("rand%0d", t), m, c, d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
